reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer_pkg.sv | 14 +
 rtl/btn_debounce.sv | 51 +++++
 rtl/reset_sequencer.sv | 123 ++++++++++++
 tb/tb_reset_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the reset sequencer and its debouncer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rs_state_e;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes the raw active-low pushbutton and accepts a level change only
// after it has been stable for DEBOUNCE_CYCLES synchronized cycles.
module btn_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_N,
  output logic PRESSED
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   pressed_q, pressed_d;
  logic                   sync_pressed;

  // Flops reset to 1 so a held button is treated as released until seen.
  assign sync_pressed = ~sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d     = '0;
    pressed_d = pressed_q;
    if (sync_pressed != pressed_q) begin
      if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        pressed_d = sync_pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q    <= '1;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], BTN_N};
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  assign PRESSED = pressed_q;

endmodule

// File: rtl/reset_sequencer.sv
// Stretches power-on and debounced button resets, then releases the domain
// resets one by one with a fixed gap; READY marks the final release.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_DOMAINS     = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8,
  parameter int GAP_CYCLES      = 4
) (
`ifdef PWR_PINS
  input  logic                   VDD,
  input  logic                   GND,
`endif
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   BTN_N,
  output logic [NUM_DOMAINS-1:0] RESET_N,
  output logic                   READY,
  output logic                   BTN_CAUSE
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam int IDX_W   = cnt_width(NUM_DOMAINS);

  rs_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rstn_q, rstn_d;
  logic                   ready_q, ready_d;
  logic                   cause_q, cause_d;
  logic                   btn_pressed;

  btn_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .CLK    (CLK),
    .RST    (RST),
    .BTN_N  (BTN_N),
    .PRESSED(btn_pressed)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rstn_d  = rstn_q;
    ready_d = ready_q;
    cause_d = cause_q;

    // A held button overrides every state and keeps the hold counter at zero.
    if (btn_pressed) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rstn_d  = '0;
      ready_d = 1'b0;
      cause_d = 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_d     = '0;
            rstn_d[0] = 1'b1;
            if (NUM_DOMAINS == 1) begin
              ready_d = 1'b1;
              state_d = RUN;
            end else begin
              idx_d   = IDX_W'(1);
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
            cnt_d = '0;
            for (int i = 0; i < NUM_DOMAINS; i++) begin
              if (IDX_W'(i) == idx_q) rstn_d[i] = 1'b1;
            end
            if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
              ready_d = 1'b1;
              state_d = RUN;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: ;
        default: state_d = HOLD;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rstn_q  <= '0;
      ready_q <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rstn_q  <= rstn_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  assign RESET_N   = rstn_q;
  assign READY     = ready_q;
  assign BTN_CAUSE = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default, single-domain and long-gap builds.
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       btn_n;
  logic       btn_g;
  logic [2:0] rn;
  logic       rdy, cause;
  logic [0:0] rn1;
  logic       rdy1, cause1;
  logic [2:0] rng;
  logic       rdyg, causeg;

  int checks;
  int errors;

  reset_sequencer dut (
`ifdef PWR_PINS
    .VDD(1'b1), .GND(1'b0),
`endif
    .CLK(clk), .RST(rst), .BTN_N(btn_n),
    .RESET_N(rn), .READY(rdy), .BTN_CAUSE(cause)
  );

  reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(1)) dut1 (
`ifdef PWR_PINS
    .VDD(1'b1), .GND(1'b0),
`endif
    .CLK(clk), .RST(rst), .BTN_N(btn_n),
    .RESET_N(rn1), .READY(rdy1), .BTN_CAUSE(cause1)
  );

  reset_sequencer #(.GAP_CYCLES(20)) dutg (
`ifdef PWR_PINS
    .VDD(1'b1), .GND(1'b0),
`endif
    .CLK(clk), .RST(rst), .BTN_N(btn_g),
    .RESET_N(rng), .READY(rdyg), .BTN_CAUSE(causeg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    btn_n = 1'b1;
    btn_g = 1'b1;
    #2;
    checks++; if (rn !== 3'b000) begin errors++; $display("FAIL reset_rn got %b want 000", rn); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", rdy); end
    checks++; if (cause !== 1'b0) begin errors++; $display("FAIL reset_cause got %b want 0", cause); end
    tick();
    tick();
    checks++; if (rn !== 3'b000 || rdy !== 1'b0) begin errors++; $display("FAIL reset_held got %b/%b want 000/0", rn, rdy); end
  endtask

  task automatic test_por();
    logic [2:0] exp;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp = (e >= 16) ? 3'b111 : (e >= 12) ? 3'b011 : (e >= 8) ? 3'b001 : 3'b000;
      checks++; if (rn !== exp) begin errors++; $display("FAIL por_rn edge %0d got %b want %b", e, rn, exp); end
      checks++; if (rdy !== (e >= 16)) begin errors++; $display("FAIL por_ready edge %0d got %b want %b", e, rdy, (e >= 16)); end
      checks++; if (cause !== 1'b0) begin errors++; $display("FAIL por_cause edge %0d got %b want 0", e, cause); end
    end
  endtask

  task automatic test_single_domain();
    rst = 1'b1;
    #2;
    checks++; if (rn1 !== 1'b0 || rdy1 !== 1'b0) begin errors++; $display("FAIL single_reset got %b/%b want 0/0", rn1, rdy1); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (rn1 !== 1'b0) begin errors++; $display("FAIL single_edge0 got %b want 0", rn1); end
    tick();
    checks++; if (rn1 !== 1'b1) begin errors++; $display("FAIL single_rn_edge1 got %b want 1", rn1); end
    checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL single_ready_edge1 got %b want 1", rdy1); end
    checks++; if (cause1 !== 1'b0) begin errors++; $display("FAIL single_cause got %b want 0", cause1); end
    for (int i = 0; i < 20; i++) tick();
  endtask

  task automatic test_button();
    checks++; if (rn !== 3'b111 || rdy !== 1'b1) begin errors++; $display("FAIL btn_precond got %b/%b want 111/1", rn, rdy); end
    btn_n = 1'b0;
    for (int e = 1; e <= 74; e++) begin
      tick();
      if (e == 40) btn_n = 1'b1;
      if (e == 18) begin
        checks++; if (rn !== 3'b111 || rdy !== 1'b1) begin errors++; $display("FAIL btn_edge18 got %b/%b want 111/1", rn, rdy); end
      end
      if (e == 19) begin
        checks++; if (rn !== 3'b000) begin errors++; $display("FAIL btn_drop_rn got %b want 000", rn); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL btn_drop_ready got %b want 0", rdy); end
        checks++; if (cause !== 1'b1) begin errors++; $display("FAIL btn_drop_cause got %b want 1", cause); end
      end
      if (e == 65) begin
        checks++; if (rn !== 3'b000) begin errors++; $display("FAIL btn_edge65 got %b want 000", rn); end
      end
      if (e == 66) begin
        checks++; if (rn !== 3'b001) begin errors++; $display("FAIL btn_edge66 got %b want 001", rn); end
      end
      if (e == 70) begin
        checks++; if (rn !== 3'b011) begin errors++; $display("FAIL btn_edge70 got %b want 011", rn); end
      end
      if (e == 73) begin
        checks++; if (rn !== 3'b011 || rdy !== 1'b0) begin errors++; $display("FAIL btn_edge73 got %b/%b want 011/0", rn, rdy); end
      end
      if (e == 74) begin
        checks++; if (rn !== 3'b111 || rdy !== 1'b1) begin errors++; $display("FAIL btn_edge74 got %b/%b want 111/1", rn, rdy); end
        checks++; if (cause !== 1'b1) begin errors++; $display("FAIL btn_cause_sticky got %b want 1", cause); end
      end
    end
  endtask

  task automatic test_bounce();
    for (int p = 0; p < 4; p++) begin
      btn_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        checks++; if (rn !== 3'b111 || rdy !== 1'b1) begin errors++; $display("FAIL bounce_low p%0d c%0d got %b/%b want 111/1", p, i, rn, rdy); end
      end
      btn_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tick();
        checks++; if (rn !== 3'b111 || rdy !== 1'b1) begin errors++; $display("FAIL bounce_high p%0d c%0d got %b/%b want 111/1", p, i, rn, rdy); end
      end
    end
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++; if (rn !== 3'b111 || rdy !== 1'b1) begin errors++; $display("FAIL bounce_settle c%0d got %b/%b want 111/1", i, rn, rdy); end
    end
  endtask

  task automatic test_rst_mid();
    btn_n = 1'b0;
    for (int e = 1; e <= 47; e++) begin
      tick();
      if (e == 20) btn_n = 1'b1;
    end
    checks++; if (rn !== 3'b001 || cause !== 1'b1) begin errors++; $display("FAIL rstmid_precond got %b/%b want 001/1", rn, cause); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rn !== 3'b000) begin errors++; $display("FAIL rstmid_rn got %b want 000", rn); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b want 0", rdy); end
    checks++; if (cause !== 1'b0) begin errors++; $display("FAIL rstmid_cause got %b want 0", cause); end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 7) begin
        checks++; if (rn !== 3'b000) begin errors++; $display("FAIL rstmid_edge7 got %b want 000", rn); end
      end
      if (e == 8) begin
        checks++; if (rn !== 3'b001) begin errors++; $display("FAIL rstmid_edge8 got %b want 001", rn); end
      end
      if (e == 12) begin
        checks++; if (rn !== 3'b011) begin errors++; $display("FAIL rstmid_edge12 got %b want 011", rn); end
      end
      if (e == 16) begin
        checks++; if (rn !== 3'b111 || rdy !== 1'b1) begin errors++; $display("FAIL rstmid_edge16 got %b/%b want 111/1", rn, rdy); end
      end
    end
  endtask

  task automatic test_press_in_release();
    rst   = 1'b1;
    btn_g = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 96; e++) begin
      tick();
      if (e == 30) btn_g = 1'b1;
      if (e == 8 || e == 18) begin
        checks++; if (rng !== 3'b001) begin errors++; $display("FAIL pir_edge%0d got %b want 001", e, rng); end
      end
      if (e == 19) begin
        checks++; if (rng !== 3'b000) begin errors++; $display("FAIL pir_drop_rn got %b want 000", rng); end
        checks++; if (rdyg !== 1'b0 || causeg !== 1'b1) begin errors++; $display("FAIL pir_drop_flags got %b/%b want 0/1", rdyg, causeg); end
      end
      if (e == 28 || e == 55) begin
        checks++; if (rng !== 3'b000) begin errors++; $display("FAIL pir_edge%0d got %b want 000", e, rng); end
      end
      if (e == 56 || e == 75) begin
        checks++; if (rng !== 3'b001) begin errors++; $display("FAIL pir_edge%0d got %b want 001", e, rng); end
      end
      if (e == 76) begin
        checks++; if (rng !== 3'b011) begin errors++; $display("FAIL pir_edge76 got %b want 011", rng); end
      end
      if (e == 96) begin
        checks++; if (rng !== 3'b111 || rdyg !== 1'b1) begin errors++; $display("FAIL pir_edge96 got %b/%b want 111/1", rng, rdyg); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_por();
    test_single_domain();
    test_button();
    test_bounce();
    test_rst_mid();
    test_press_in_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
